// File: rtl/i2c_rx_pkg.sv
// Shared encodings for the I2C receive sequencer: FSM states, SDA drive levels
// and the bank-index width helper.
package i2c_rx_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_SHIFT = 2'd1;
   localparam state_t ST_ACK   = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   // sda_oe levels: pulling SDA low is an ACK, releasing it is a NACK
   localparam logic SDA_ACK  = 1'b1;
   localparam logic SDA_NACK = 1'b0;

   function automatic int bank_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rx_byte_buffer.sv
// NUM_BANKS-deep ring of received bytes. A push into a full ring is accepted
// when a pop happens in the same cycle.
module rx_byte_buffer
   import i2c_rx_pkg::*;
#(
   parameter int  DATA_W    = 8,
   parameter int  NUM_BANKS = 2,
   localparam int BANK_W    = bank_w(NUM_BANKS),
   localparam int OCC_W     = $clog2(NUM_BANKS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              accept,
   output logic [DATA_W-1:0] rd_data,
   output logic [BANK_W-1:0] rd_ptr,
   output logic [OCC_W-1:0]  count
);

   logic [NUM_BANKS-1:0][DATA_W-1:0] mem;
   logic [BANK_W-1:0]                wr_ptr;
   logic                             full, pop_ok;

   assign full    = (count == OCC_W'(NUM_BANKS));
   assign pop_ok  = pop && (count != '0);
   assign accept  = push && (!full || pop_ok);
   assign rd_data = mem[rd_ptr];

   // Storage is cleared on reset so rd_data reads zero out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
         count <= count + OCC_W'(accept) - OCC_W'(pop_ok);
      end
   end

endmodule

// File: rtl/i2c_rx_sequencer.sv
// Receive sequencer: shifts serial bits into bytes, pushes them into the bank
// ring and drives ACK/NACK on SDA for every byte.
module i2c_rx_sequencer
   import i2c_rx_pkg::*;
#(
   parameter int  DATA_W    = 8,
   parameter int  CNT_W     = 7,
   parameter int  NUM_BANKS = 2,
   localparam int BANK_W    = bank_w(NUM_BANKS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_rx,
   input  logic [CNT_W-1:0]  rx_len,
   input  logic              bit_valid,
   input  logic              bit_in,
   input  logic              ack_slot,
   input  logic              rx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic [BANK_W-1:0] rx_bank,
   output logic              rx_valid,
   output logic              sda_oe,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic              overflow,
   output logic [CNT_W-1:0]  bytes_left
);

   localparam int BC_W  = $clog2(DATA_W);
   localparam int OCC_W = $clog2(NUM_BANKS + 1);

   state_t            state, state_nx;
   logic              armed, nack;
   logic [DATA_W-1:0] shreg, byte_nx;
   logic [BC_W-1:0]   bit_cnt;
   logic [OCC_W-1:0]  occ;
   logic              start_go, abort_go, shift_en, last_bit, ack_en;
   logic              push_ok, pop, ack_byte;
   logic              busy_nx, done_nx, aborted_nx;

   // armed gives edge-qualified restart: start_rx must drop before a new start
   assign start_go = (state == ST_IDLE) && start_rx && armed;
   assign abort_go = ((state == ST_SHIFT) || (state == ST_ACK)) && !start_rx;
   assign shift_en = (state == ST_SHIFT) && start_rx && bit_valid;
   assign last_bit = shift_en && (bit_cnt == BC_W'(DATA_W - 1));
   assign ack_en   = (state == ST_ACK) && start_rx && ack_slot;
   assign byte_nx  = {shreg[DATA_W-2:0], bit_in};
   assign pop      = rx_valid && rx_ready;
   assign ack_byte = push_ok && (bytes_left > CNT_W'(1));
   assign rx_valid = (occ != '0);

   rx_byte_buffer #(.DATA_W(DATA_W), .NUM_BANKS(NUM_BANKS)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (last_bit),
      .push_data (byte_nx),
      .pop       (pop),
      .accept    (push_ok),
      .rd_data   (rx_data),
      .rd_ptr    (rx_bank),
      .count     (occ)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (start_go) state_nx = (rx_len == '0) ? ST_DONE : ST_SHIFT;
         ST_SHIFT: if (!start_rx) state_nx = ST_IDLE;
                   else if (last_bit) state_nx = ST_ACK;
         ST_ACK:   if (!start_rx) state_nx = ST_IDLE;
                   else if (ack_slot) state_nx = nack ? ST_DONE : ST_SHIFT;
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_nx    = (state_nx != ST_IDLE);
      done_nx    = (state_nx == ST_DONE);
      aborted_nx = abort_go;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         armed      <= 1'b1;
         nack       <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= '0;
         sda_oe     <= SDA_NACK;
         busy       <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         overflow   <= 1'b0;
         bytes_left <= '0;
      end else begin
         busy    <= busy_nx;
         done    <= done_nx;
         aborted <= aborted_nx;
         if (!start_rx)     armed <= 1'b1;
         else if (start_go) armed <= 1'b0;
         if (start_go) begin
            bytes_left <= rx_len;
            overflow   <= 1'b0;
            bit_cnt    <= '0;
         end
         if (shift_en) begin
            shreg   <= byte_nx;
            bit_cnt <= bit_cnt + 1'b1;
         end
         // A dropped byte or the final byte ends the transfer with a NACK
         if (last_bit) begin
            bit_cnt <= '0;
            nack    <= !ack_byte;
            sda_oe  <= ack_byte ? SDA_ACK : SDA_NACK;
            if (!push_ok) overflow <= 1'b1;
         end
         if (ack_en) begin
            sda_oe <= SDA_NACK;
            if (bytes_left != '0) bytes_left <= bytes_left - 1'b1;
         end
         if (abort_go) sda_oe <= SDA_NACK;
      end
   end

endmodule

// File: tb/tb_i2c_rx_sequencer.sv
// Directed bench for i2c_rx_sequencer: a table of full transfers plus
// hand-written overflow, abort, zero-length, reset and full-ring sequences.
module tb_i2c_rx_sequencer;

   localparam int DATA_W    = 8;
   localparam int CNT_W     = 7;
   localparam int NUM_BANKS = 2;

   logic              clk = 1'b0;
   logic              rst, start_rx, bit_valid, bit_in, ack_slot, rx_ready;
   logic [CNT_W-1:0]  rx_len;
   logic [DATA_W-1:0] rx_data;
   logic [0:0]        rx_bank;
   logic              rx_valid, sda_oe, busy, done, aborted, overflow;
   logic [CNT_W-1:0]  bytes_left;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [7:0] got_q[$];
   logic       got_bank_q[$];

   typedef struct {
      int              len;
      logic [2:0][7:0] d;
      logic [2:0]      ack;
   } vec_t;
   vec_t vt[3];

   i2c_rx_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .NUM_BANKS(NUM_BANKS)) dut (
      .clk(clk), .rst(rst), .start_rx(start_rx), .rx_len(rx_len),
      .bit_valid(bit_valid), .bit_in(bit_in), .ack_slot(ack_slot),
      .rx_ready(rx_ready), .rx_data(rx_data), .rx_bank(rx_bank),
      .rx_valid(rx_valid), .sda_oe(sda_oe), .busy(busy), .done(done),
      .aborted(aborted), .overflow(overflow), .bytes_left(bytes_left)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid && rx_ready) begin
            got_q.push_back(rx_data);
            got_bank_q.push_back(rx_bank[0]);
         end
         if (done) done_cnt++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start_rx = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
      ack_slot = 1'b0; rx_ready = 1'b0; rx_len = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // MSB first with an idle cycle between bits; ack_slot on the first bit
   // must be ignored. Returns one cycle after the final bit.
   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         bit_valid = 1'b1; bit_in = b[i]; ack_slot = (i == 7);
         tick();
         bit_valid = 1'b0; ack_slot = 1'b0;
         if (i != 0) tick();
      end
   endtask

   // A stray bit_valid in ACK, then the ack slot. Returns one cycle after it.
   task automatic do_ack();
      bit_valid = 1'b1; bit_in = 1'b1;
      tick();
      bit_valid = 1'b0;
      ack_slot = 1'b1;
      tick();
      ack_slot = 1'b0;
   endtask

   initial begin
      vt[0] = '{3, {8'hFF, 8'h3C, 8'hA5}, 3'b011};
      vt[1] = '{1, {8'h00, 8'h00, 8'h5A}, 3'b000};
      vt[2] = '{2, {8'h00, 8'h81, 8'h00}, 3'b001};

      do_reset();
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_bank", rx_bank, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_aborted", aborted, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_bytes_left", bytes_left, 0);

      for (int v = 0; v < 3; v++) begin
         do_reset();
         got_q.delete(); got_bank_q.delete(); done_cnt = 0;
         rx_ready = 1'b1; start_rx = 1'b1; rx_len = CNT_W'(vt[v].len);
         tick();
         chk("vec_busy", busy, 1);
         chk("vec_len", bytes_left, vt[v].len);
         for (int k = 0; k < vt[v].len; k++) begin
            send_byte(vt[v].d[k]);
            chk("vec_valid", rx_valid, 1);
            chk("vec_data", rx_data, vt[v].d[k]);
            chk("vec_sda", sda_oe, vt[v].ack[k]);
            do_ack();
            chk("vec_sda_rel", sda_oe, 0);
            chk("vec_left", bytes_left, vt[v].len - k - 1);
         end
         chk("vec_done", done, 1);
         tick();
         chk("vec_done_end", done, 0);
         chk("vec_idle", busy, 0);
         start_rx = 1'b0;
         tick();
         chk("vec_nbytes", got_q.size(), vt[v].len);
         for (int k = 0; k < vt[v].len && k < got_q.size(); k++) begin
            chk("vec_got", got_q[k], vt[v].d[k]);
            chk("vec_bank", got_bank_q[k], k % 2);
         end
         chk("vec_done_cnt", done_cnt, 1);
      end

      // overflow: consumer stalled, third byte has nowhere to go
      do_reset();
      start_rx = 1'b1; rx_len = 7'd4;
      tick();
      send_byte(8'h11); chk("ovf_sda1", sda_oe, 1); do_ack();
      send_byte(8'h22); chk("ovf_sda2", sda_oe, 1); chk("ovf_clear", overflow, 0); do_ack();
      send_byte(8'h33); chk("ovf_sda3", sda_oe, 0); chk("ovf_set", overflow, 1); do_ack();
      chk("ovf_done", done, 1);
      chk("ovf_left", bytes_left, 1);
      tick();
      chk("ovf_idle", busy, 0);
      chk("ovf_sticky", overflow, 1);
      chk("ovf_head", rx_data, 8'h11);
      chk("ovf_bank0", rx_bank, 0);
      rx_ready = 1'b1;
      tick();
      chk("ovf_next", rx_data, 8'h22);
      chk("ovf_bank1", rx_bank, 1);
      chk("ovf_valid", rx_valid, 1);
      tick();
      chk("ovf_empty", rx_valid, 0);
      rx_ready = 1'b0; start_rx = 1'b0;
      tick();

      // abort after five bits of the second byte
      do_reset();
      done_cnt = 0;
      start_rx = 1'b1; rx_len = 7'd3;
      tick();
      send_byte(8'h5A); chk("abt_sda1", sda_oe, 1); do_ack();
      for (int i = 7; i >= 3; i--) begin
         bit_valid = 1'b1; bit_in = i[0];
         tick();
         bit_valid = 1'b0;
      end
      start_rx = 1'b0;
      tick();
      chk("abt_pulse", aborted, 1);
      chk("abt_busy", busy, 0);
      chk("abt_sda", sda_oe, 0);
      chk("abt_kept", rx_valid, 1);
      chk("abt_data", rx_data, 8'h5A);
      tick();
      chk("abt_pulse_end", aborted, 0);
      chk("abt_no_done", done_cnt, 0);

      // zero-length transfer and edge-qualified restart
      do_reset();
      done_cnt = 0;
      start_rx = 1'b1; rx_len = 7'd0;
      tick();
      chk("zero_done", done, 1);
      chk("zero_sda", sda_oe, 0);
      tick();
      chk("zero_done_end", done, 0);
      chk("zero_idle", busy, 0);
      rx_len = 7'd2;
      repeat (3) tick();
      chk("hold_no_start", busy, 0);
      chk("hold_done_cnt", done_cnt, 1);
      start_rx = 1'b0;
      tick();
      start_rx = 1'b1; rx_len = 7'd0;
      tick();
      chk("restart_done", done, 1);
      start_rx = 1'b0;
      tick();

      // reset while ACK is being driven
      do_reset();
      start_rx = 1'b1; rx_len = 7'd2;
      tick();
      send_byte(8'h77);
      chk("rsa_sda", sda_oe, 1);
      chk("rsa_valid", rx_valid, 1);
      rst = 1'b1; start_rx = 1'b0;
      tick();
      chk("rsa_sda_clr", sda_oe, 0);
      chk("rsa_valid_clr", rx_valid, 0);
      chk("rsa_busy", busy, 0);
      chk("rsa_left", bytes_left, 0);
      chk("rsa_data", rx_data, 0);
      chk("rsa_bank", rx_bank, 0);
      rst = 1'b0;

      // full ring: push and pop in the same cycle
      do_reset();
      start_rx = 1'b1; rx_len = 7'd4;
      tick();
      send_byte(8'h10); do_ack();
      send_byte(8'h20); do_ack();
      for (int i = 7; i >= 0; i--) begin
         bit_valid = 1'b1; bit_in = (i == 4) || (i == 5);
         rx_ready = (i == 0);
         tick();
         bit_valid = 1'b0; rx_ready = 1'b0;
         if (i != 0) tick();
      end
      chk("pp_sda", sda_oe, 1);
      chk("pp_overflow", overflow, 0);
      chk("pp_valid", rx_valid, 1);
      chk("pp_head", rx_data, 8'h20);
      chk("pp_bank", rx_bank, 1);
      rx_ready = 1'b1;
      tick();
      chk("pp_new", rx_data, 8'h30);
      rx_ready = 1'b0; start_rx = 1'b0;
      tick();
      chk("pp_abort", aborted, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
